// File: rtl/pad_poller_pkg.sv
// Shared types and constants for the serial game-pad poller.
// Button indices follow the NES controller shift order.
package pad_poller_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SHIFT_LO,
      SHIFT_HI,
      DONE
   } state_t;

   localparam int NES_BITS  = 8;
   localparam int SNES_BITS = 16;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/pad_shift_channel.sv
// One pad's capture path: shadow frame, previous frame,
// published button word and pressed/released edge flags.
module pad_shift_channel
   import pad_poller_pkg::*;
#(
   parameter int NUM_BITS   = NES_BITS,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        sample_en,
   input  logic                        commit,
   input  logic [$clog2(NUM_BITS)-1:0] bit_idx,
   input  logic                        data,
   output logic [NUM_BITS-1:0]         buttons,
   output logic [NUM_BITS-1:0]         pressed,
   output logic [NUM_BITS-1:0]         released
);

   localparam logic INV = (ACTIVE_LOW != 0);

   logic [NUM_BITS-1:0] shadow;
   logic [NUM_BITS-1:0] shadow_nxt;
   logic [NUM_BITS-1:0] prev;

   // The last sample lands in the same edge as the commit.
   always_comb begin
      shadow_nxt = shadow;
      if (sample_en)
         shadow_nxt[bit_idx] = data ^ INV;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow   <= '0;
         prev     <= '0;
         buttons  <= '0;
         pressed  <= '0;
         released <= '0;
      end else begin
         shadow   <= shadow_nxt;
         pressed  <= '0;
         released <= '0;
         if (commit) begin
            buttons  <= shadow_nxt;
            pressed  <= shadow_nxt & ~prev;
            released <= ~shadow_nxt & prev;
            prev     <= shadow_nxt;
         end
      end
   end

endmodule

// File: rtl/pad_poller.sv
// Polls NUM_PADS serial game pads over a shared latch/pulse pair
// and publishes one registered button frame per poll.
module pad_poller
   import pad_poller_pkg::*;
#(
   parameter int NUM_PADS    = 2,
   parameter int NUM_BITS    = NES_BITS,
   parameter int HALF_PERIOD = 1,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NUM_PADS-1:0]          pad_data,
   output logic                         pad_latch,
   output logic                         pad_pulse,
   output logic                         busy,
   output logic [NUM_PADS*NUM_BITS-1:0] buttons,
   output logic [NUM_PADS*NUM_BITS-1:0] pressed,
   output logic [NUM_PADS*NUM_BITS-1:0] released,
   output logic                         frame_valid
);

   localparam int TW = $clog2(2*HALF_PERIOD+1);
   localparam int BW = $clog2(NUM_BITS);

   localparam logic [TW-1:0] LAT_END  = TW'(2*HALF_PERIOD-1);
   localparam logic [TW-1:0] PH_END   = TW'(HALF_PERIOD-1);
   localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS-1);

   state_t        state;
   logic [TW-1:0] timer;
   logic [BW-1:0] bit_idx;
   logic          sample_en;
   logic          commit;

   assign sample_en = (state == SHIFT_LO) && (timer == PH_END);
   assign commit    = sample_en && (bit_idx == LAST_BIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         bit_idx     <= '0;
         pad_latch   <= 1'b0;
         pad_pulse   <= 1'b0;
         busy        <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= commit;
         unique case (state)
            IDLE: begin
               timer <= '0;
               if (start) begin
                  state     <= LATCH;
                  pad_latch <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            LATCH: begin
               if (timer == LAT_END) begin
                  state     <= SHIFT_LO;
                  timer     <= '0;
                  bit_idx   <= '0;
                  pad_latch <= 1'b0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            SHIFT_LO: begin
               if (timer == PH_END) begin
                  timer <= '0;
                  if (bit_idx == LAST_BIT) begin
                     state <= DONE;
                  end else begin
                     state     <= SHIFT_HI;
                     pad_pulse <= 1'b1;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            SHIFT_HI: begin
               if (timer == PH_END) begin
                  state     <= SHIFT_LO;
                  timer     <= '0;
                  bit_idx   <= bit_idx + BW'(1);
                  pad_pulse <= 1'b0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               timer     <= '0;
               bit_idx   <= '0;
               pad_latch <= 1'b0;
               pad_pulse <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      pad_shift_channel #(
         .NUM_BITS   (NUM_BITS),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .sample_en (sample_en),
         .commit    (commit),
         .bit_idx   (bit_idx),
         .data      (pad_data[p]),
         .buttons   (buttons[p*NUM_BITS +: NUM_BITS]),
         .pressed   (pressed[p*NUM_BITS +: NUM_BITS]),
         .released  (released[p*NUM_BITS +: NUM_BITS])
      );
   end

endmodule

// File: tb/tb_pad_poller.sv
// Directed bench: NES (8 bit, H=1, active-low) and SNES
// (16 bit, H=3, active-high) pollers against a pad shift model.
module tb_pad_poller;
   import pad_poller_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic [1:0] noise = 2'b00;
   logic [1:0] pd_a, pd_b;

   logic a_latch, a_pulse, a_busy, a_fv;
   logic [15:0] a_btn, a_prs, a_rel;
   logic b_latch, b_pulse, b_busy, b_fv;
   logic [31:0] b_btn, b_prs, b_rel;

   logic [7:0]  ra0 = '1, ra1 = '1, sa0 = '1, sa1 = '1;
   logic [15:0] rb0 = '0, rb1 = '0, sb0 = '0, sb1 = '0;
   logic pqa = 1'b0, pqb = 1'b0;

   int checks = 0;
   int errors = 0;

   int lat_cnt, lat_first, lat_last, pul_cnt, hi_cnt;
   int busy_cnt, stray;
   int fvq[$];
   logic [31:0] cap_btn, cap_prs, cap_rel;

   always #5 clk = ~clk;

   pad_poller #(
      .NUM_PADS(2), .NUM_BITS(NES_BITS),
      .HALF_PERIOD(1), .ACTIVE_LOW(1)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .pad_data(pd_a), .pad_latch(a_latch),
      .pad_pulse(a_pulse), .busy(a_busy),
      .buttons(a_btn), .pressed(a_prs),
      .released(a_rel), .frame_valid(a_fv)
   );

   pad_poller #(
      .NUM_PADS(2), .NUM_BITS(SNES_BITS),
      .HALF_PERIOD(3), .ACTIVE_LOW(0)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
      .pad_data(pd_b), .pad_latch(b_latch),
      .pad_pulse(b_pulse), .busy(b_busy),
      .buttons(b_btn), .pressed(b_prs),
      .released(b_rel), .frame_valid(b_fv)
   );

   // Pad model: load while latched, shift on each pulse rise.
   assign pd_a = {sa1[0], sa0[0]} ^ noise;
   assign pd_b = {sb1[0], sb0[0]};

   always @(posedge clk) begin
      pqa <= a_pulse;
      pqb <= b_pulse;
      if (a_latch) begin
         sa0 <= ra0;
         sa1 <= ra1;
      end else if (a_pulse && !pqa) begin
         sa0 <= {1'b1, sa0[7:1]};
         sa1 <= {1'b1, sa1[7:1]};
      end
      if (b_latch) begin
         sb0 <= rb0;
         sb1 <= rb1;
      end else if (b_pulse && !pqb) begin
         sb0 <= {1'b0, sb0[15:1]};
         sb1 <= {1'b0, sb1[15:1]};
      end
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic run(input bit sel, input int ncyc,
                      input bit hold, input int s1,
                      input int s2);
      logic lt, pu, bz, fv, pq, st;
      logic [31:0] bt, pr, rl;
      lat_cnt = 0; lat_first = -1; lat_last = -1;
      pul_cnt = 0; hi_cnt = 0; busy_cnt = 0; stray = 0;
      fvq.delete();
      cap_btn = '0; cap_prs = '0; cap_rel = '0;
      pq = 1'b0;
      for (int c = 0; c <= ncyc; c++) begin
         @(negedge clk);
         st = hold || c == 0 || c == s1 || c == s2;
         if (sel) start_b = st;
         else start_a = st;
         lt = sel ? b_latch : a_latch;
         pu = sel ? b_pulse : a_pulse;
         bz = sel ? b_busy : a_busy;
         fv = sel ? b_fv : a_fv;
         bt = sel ? b_btn : {16'h0, a_btn};
         pr = sel ? b_prs : {16'h0, a_prs};
         rl = sel ? b_rel : {16'h0, a_rel};
         if (lt) begin
            lat_cnt++;
            if (lat_first < 0) lat_first = c;
            lat_last = c;
         end
         if (pu) hi_cnt++;
         if (pu && !pq) pul_cnt++;
         pq = pu;
         if (bz) busy_cnt++;
         if (fv) begin
            fvq.push_back(c);
            cap_btn = bt;
            cap_prs = pr;
            cap_rel = rl;
         end else if (pr != 0 || rl != 0) begin
            stray++;
         end
      end
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   initial begin
      int n;
      // 1: reset held with start and toggling data
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start_a = 1'b1;
         start_b = 1'b1;
         noise = ~noise;
         check("rst_out",
               {a_latch, a_pulse, a_busy, a_fv,
                |a_btn, |a_prs, |a_rel,
                b_latch, b_pulse, b_busy, b_fv,
                |b_btn, |b_prs, |b_rel}, 0);
      end
      @(negedge clk);
      reset = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      noise = 2'b00;

      // 2: first NES frame, pad0 line 0,1,1,0,1,1,1,1
      ra0 = 8'hF6;
      ra1 = 8'hFF;
      run(0, 20, 0, -1, -1);
      check("t2_lat_first", lat_first, 1);
      check("t2_lat_last", lat_last, 2);
      check("t2_lat_cnt", lat_cnt, 2);
      check("t2_pulses", pul_cnt, 7);
      check("t2_pulse_hi", hi_cnt, 7);
      check("t2_busy_cnt", busy_cnt, 18);
      check("t2_fv_cnt", fvq.size(), 1);
      check("t2_fv_cyc", fvq.size() > 0 ? fvq[0] : -1, 18);
      check("t2_btn", cap_btn, 32'h0009);
      check("t2_prs", cap_prs, 32'h0009);
      check("t2_rel", cap_rel, 32'h0000);
      check("t2_stray", stray, 0);

      // 3: A released, pad1 idle
      ra0 = 8'hF7;
      ra1 = 8'hFF;
      run(0, 20, 0, -1, -1);
      check("t3_btn", cap_btn, 32'h0008);
      check("t3_prs", cap_prs, 32'h0000);
      check("t3_rel", cap_rel, 32'h0001);
      check("t3_stray", stray, 0);

      // 4a: extra start pulses while busy are dropped
      ra0 = 8'hF6;
      ra1 = 8'h3C;
      run(0, 40, 0, 5, 18);
      check("t4_fv_cnt", fvq.size(), 1);
      check("t4_busy_cnt", busy_cnt, 18);
      check("t4_btn", cap_btn, 32'hC309);
      check("t4_prs", cap_prs, 32'hC301);
      check("t4_rel", cap_rel, 32'h0000);

      // 4b: start held high repeats every 19 cycles
      run(0, 57, 1, -1, -1);
      check("t4h_fv_cnt", fvq.size(), 3);
      check("t4h_fv0", fvq.size() > 0 ? fvq[0] : -1, 18);
      check("t4h_fv1", fvq.size() > 1 ? fvq[1] : -1, 37);
      check("t4h_fv2", fvq.size() > 2 ? fvq[2] : -1, 56);
      check("t4h_btn", cap_btn, 32'hC309);
      check("t4h_prs", cap_prs, 32'h0000);
      check("t4h_rel", cap_rel, 32'h0000);
      check("t4h_stray", stray, 0);

      // 5: reset at cycle 10 of a frame
      ra1 = 8'hFF;
      @(negedge clk);
      start_a = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (c == 10) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      check("t5_latch", a_latch, 0);
      check("t5_pulse", a_pulse, 0);
      check("t5_busy", a_busy, 0);
      check("t5_btn", a_btn, 0);
      n = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (a_fv) n++;
      end
      check("t5_no_fv", n, 0);
      run(0, 20, 0, -1, -1);
      check("t5_btn2", cap_btn, 32'h0009);
      check("t5_prs2", cap_prs, 32'h0009);
      check("t5_rel2", cap_rel, 32'h0000);

      // 6: SNES, H=3, active-high data
      rb0 = 16'h1234;
      rb1 = 16'hA5C3;
      run(1, 102, 0, -1, -1);
      check("t6_lat_first", lat_first, 1);
      check("t6_lat_last", lat_last, 6);
      check("t6_lat_cnt", lat_cnt, 6);
      check("t6_pulses", pul_cnt, 15);
      check("t6_pulse_hi", hi_cnt, 45);
      check("t6_busy_cnt", busy_cnt, 100);
      check("t6_fv_cnt", fvq.size(), 1);
      check("t6_fv_cyc", fvq.size() > 0 ? fvq[0] : -1, 100);
      check("t6_btn", cap_btn, 32'hA5C3_1234);
      check("t6_prs", cap_prs, 32'hA5C3_1234);
      check("t6_rel", cap_rel, 32'h0);
      check("t6_stray", stray, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pad_poller.md
Name: pad_poller

Overview:
Parametrised serial game-pad poller: the next generation of the single-NES-pad input shift register. It drives the shared latch and pulse lines and samples NUM_PADS serial data lines in parallel. Bit count is configurable (8 for NES, 16 for SNES), and the pulse rate is set by a clock divider. Each completed frame publishes registered button words plus per-button pressed/released edge flags, for consumption by the game/display logic.

Parameters:
NUM_PADS, 2, number of pads sharing latch/pulse; each pad has its own data line (≥1)
NUM_BITS, 8, serial bits per frame (8 = NES, 16 = SNES; ≥2)
HALF_PERIOD, 1, clk cycles per pulse half-period and per latch half (≥1)
ACTIVE_LOW, 1, 1 = pad data low means pressed (sample is inverted); 0 = sample stored as-is

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  request one poll frame; sampled only in IDLE
pad_data  in  NUM_PADS  serial data; bit p belongs to pad p
pad_latch  out  1  latch strobe to all pads
pad_pulse  out  1  shift clock to all pads
busy  out  1  high in every state except IDLE
buttons  out  NUM_PADS*NUM_BITS  last complete frame; pad p bit k at index p*NUM_BITS+k; 1 = pressed
pressed  out  NUM_PADS*NUM_BITS  0→1 transitions versus the previous frame; nonzero only while frame_valid
released  out  NUM_PADS*NUM_BITS  1→0 transitions versus the previous frame; nonzero only while frame_valid
frame_valid  out  1  one-cycle pulse when buttons/pressed/released update

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; timer, bit index, shadow and previous-frame registers cleared.
- Reset wins over every other event, including mid-frame. The frame is abandoned and no frame_valid is issued.
- All outputs are registered.
- States:
  - IDLE: latch=0, pulse=0, busy=0. If start=1 → LATCH; otherwise stay.
  - LATCH: latch=1 for 2*HALF_PERIOD cycles → SHIFT_LO with bit_idx=0.
  - SHIFT_LO: pulse=0 for HALF_PERIOD cycles.
    - On the last cycle of the phase, each pad's shadow[bit_idx] <= pad_data[p] XOR ACTIVE_LOW.
    - If bit_idx = NUM_BITS-1 → DONE; otherwise → SHIFT_HI.
  - SHIFT_HI: pulse=1 for HALF_PERIOD cycles, then bit_idx+1 → SHIFT_LO.
  - DONE (1 cycle): buttons = shadow, pressed = shadow & ~prev, released = ~shadow & prev, frame_valid=1, prev <= shadow. → IDLE.
- Pulse count: NUM_BITS samples and NUM_BITS-1 pulses per frame. Bit 0 (NES: A) is sampled before the first pulse.
- Timing, with start sampled high in cycle 0 and H = HALF_PERIOD:
  - latch high in cycles 1..2H
  - shift occupies (2*NUM_BITS-1)*H cycles
  - DONE/frame_valid at cycle 1+2H+(2*NUM_BITS-1)*H; NES with H=1: cycle 18
  - IDLE in the following cycle
- start while busy (including DONE) is ignored, with no queuing. If start is held high, frames repeat every 2+2H+(2*NUM_BITS-1)*H cycles (19 for NES, H=1).
- Outside DONE: buttons holds its value; pressed, released and frame_valid are 0.
- First frame after reset: prev=0, so pressed = buttons and released = 0.
- Phase timer width = $clog2(2*HALF_PERIOD+1); bit_idx width = $clog2(NUM_BITS). No wrap occurs within a legal frame.
- Unused or illegal state encodings → IDLE.

Decomposition:
- Package pad_poller_pkg:
  - state enum typedef (IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE)
  - constants NES_BITS=8, SNES_BITS=16
  - NES bit indices: BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7
- Sub-module pad_shift_channel (NUM_BITS, ACTIVE_LOW):
  - contains one pad's shadow, prev, buttons and edge logic
  - driven by sample_en, bit_idx and commit from the top-level FSM/timer
  - instantiated NUM_PADS times via generate

Test Plan:
1. Reset held 3 cycles, with start=1 and pad_data toggling → all outputs 0; busy=0 throughout.
2. NES, H=1, ACTIVE_LOW=1: start in cycle 0, pad0 serial bits 0..7 = 0,1,1,0,1,1,1,1 → latch high cycles 1-2; 7 pulses; frame_valid only in cycle 18; buttons[7:0]=0x09; pressed[7:0]=0x09; released=0.
3. Next frame with pad0 = 1,1,1,0,1,1,1,1 → buttons[7:0]=0x08; pressed=0; released[7:0]=0x01; pad1 all-ones data → pad1 fields 0.
4. start pulsed at cycles 5 and 18 → ignored, no second frame; start held high continuously → frame_valid at cycles 18, 37, 56.
5. reset asserted at cycle 10 of a frame → next cycle latch=0, pulse=0, busy=0, buttons=0; no frame_valid; a subsequent frame reports pressed = buttons.
6. NUM_BITS=16, H=3, NUM_PADS=2 → latch high cycles 1-6; 15 pulses, each 3 cycles high; frame_valid at cycle 100; pad1 pattern 0xA5C3 (ACTIVE_LOW=0) appears at buttons[31:16].
